// File: rtl/mac_dot_if.sv
// Bundle of the operand-load, run-control, MAC-drive and result signals
// exchanged between the dot-product sequencer and its surroundings.
interface mac_dot_if;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       start;
    logic       abort;
    logic [3:0] mac_a;
    logic [3:0] mac_b;
    logic       mac_en;
    logic       mac_clr;
    logic [7:0] mac_acc;
    logic [7:0] result;
    logic       result_valid;
    logic       overflow;
    logic       mismatch;
    logic       busy;

    // Environment side: offers operands, starts runs, models the MAC.
    modport master (
        output load_valid, load_data, start, abort, mac_acc,
        input  load_ready, mac_a, mac_b, mac_en, mac_clr,
        input  result, result_valid, overflow, mismatch, busy
    );

    // Sequencer side.
    modport slave (
        input  load_valid, load_data, start, abort, mac_acc,
        output load_ready, mac_a, mac_b, mac_en, mac_clr,
        output result, result_valid, overflow, mismatch, busy
    );
endinterface

// File: rtl/mac_dot_sequencer.sv
// Buffers up to DEPTH operand pairs, feeds them to an external MAC one per
// cycle, and keeps a wide shadow sum to flag 8-bit overflow and MAC errors.
module mac_dot_sequencer #(
    parameter int DEPTH = 8,
    parameter int SUMW  = 8 + $clog2(DEPTH)
) (
    input logic     clk,
    input logic     rst,
    mac_dot_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    typedef enum logic [2:0] {IDLE, CLEAR, ISSUE, DRAIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [7:0]      buffer [DEPTH];
    logic [CW-1:0]   count;
    logic [CW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [SUMW-1:0] shadow;
    logic [7:0]      result_q;
    logic            overflow_q;
    logic            mismatch_q;
    logic [7:0]      cur_pair;
    logic            accept;
    logic            last_pair;

    // Zero-extended 4x4 product; the multiply is done at 8 bits so no
    // product bits are lost before widening to the shadow width.
    function automatic logic [SUMW-1:0] prod_ext(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = {4'b0, a} * {4'b0, b};
        return SUMW'(p);
    endfunction

    assign cur_pair  = buffer[rd_ptr[AW-1:0]];
    assign accept    = bus.load_valid && bus.load_ready;
    assign last_pair = (rd_ptr == count - CW'(1));

    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;
    assign bus.mismatch = mismatch_q;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; abort overrides every other transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && (count != '0 || accept)) state_nxt = CLEAR;
            CLEAR:   state_nxt = ISSUE;
            ISSUE:   if (last_pair) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.abort) state_nxt = IDLE;
    end

    // Output decode; MAC drive is zero outside CLEAR/ISSUE, and an abort
    // landing on DONE suppresses the result pulse.
    always_comb begin
        bus.load_ready   = (state == IDLE) && (count < CW'(DEPTH));
        bus.busy         = (state != IDLE);
        bus.result_valid = (state == DONE) && !bus.abort;
        bus.mac_clr      = 1'b0;
        bus.mac_en       = 1'b0;
        bus.mac_a        = 4'd0;
        bus.mac_b        = 4'd0;
        case (state)
            CLEAR: bus.mac_clr = 1'b1;
            ISSUE: begin
                bus.mac_en = 1'b1;
                bus.mac_a  = cur_pair[3:0];
                bus.mac_b  = cur_pair[7:4];
            end
            default: ;
        endcase
    end

    // Operand storage; contents need no reset because count governs validity.
    // A pair offered in the same cycle as an abort is dropped with the rest.
    always_ff @(posedge clk) begin
        if (accept && !bus.abort) buffer[wr_ptr] <= bus.load_data;
    end

    // Counters, shadow sum and captured result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            shadow     <= '0;
            result_q   <= 8'd0;
            overflow_q <= 1'b0;
            mismatch_q <= 1'b0;
        end else if (bus.abort) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wr_ptr <= wr_ptr + AW'(1);
                        count  <= count + CW'(1);
                    end
                end
                CLEAR: begin
                    shadow <= '0;
                    rd_ptr <= '0;
                end
                ISSUE: begin
                    shadow <= shadow + prod_ext(cur_pair[3:0], cur_pair[7:4]);
                    rd_ptr <= rd_ptr + CW'(1);
                end
                DRAIN: begin
                    result_q   <= bus.mac_acc;
                    overflow_q <= (shadow > SUMW'(255));
                    mismatch_q <= (bus.mac_acc != shadow[7:0]);
                end
                DONE: begin
                    count  <= '0;
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer: a registered 8-bit MAC model,
// stimulus pushing hand-computed results into a scoreboard, and a monitor
// that pops and compares on every result_valid.
module tb_mac_dot_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    mac_dot_if bus();

    mac_dot_sequencer #(.DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] res;
        logic       ovf;
        logic       mis;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // MAC model: clear or accumulate on the edge; optional +1 fault on a
    // selected pulse to exercise the mismatch checker.
    logic [7:0] acc;
    int         en_idx;
    int         inject_at = -1;
    assign bus.mac_acc = acc;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= 8'd0;
            en_idx <= 0;
        end else if (bus.mac_clr) begin
            acc    <= 8'd0;
            en_idx <= 0;
        end else if (bus.mac_en) begin
            acc    <= acc + ({4'b0, bus.mac_a} * {4'b0, bus.mac_b})
                      + ((en_idx == inject_at) ? 8'd1 : 8'd0);
            en_idx <= en_idx + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every result pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got result %0d, expected no result_valid", bus.result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result",   32'(bus.result),   32'(e.res));
                check("overflow", 32'(bus.overflow), 32'(e.ovf));
                check("mismatch", 32'(bus.mismatch), 32'(e.mis));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [3:0] b);
        bus.load_valid = 1'b1;
        bus.load_data  = {b, a};
        tick();
        bus.load_valid = 1'b0;
    endtask

    // Start a run of n pairs (optionally loading one more pair in the start
    // cycle), optionally re-pulse start in cycle restart_k, and check the
    // clear/issue counts and the result_valid latency.
    task automatic run(input int n, input logic with_load, input logic [3:0] a,
                       input logic [3:0] b, input int restart_k);
        int clr_n = 0;
        int en_n  = 0;
        int rv_k  = 0;
        bus.start = 1'b1;
        if (with_load) begin
            bus.load_valid = 1'b1;
            bus.load_data  = {b, a};
        end
        tick();
        bus.start      = 1'b0;
        bus.load_valid = 1'b0;
        for (int k = 1; k <= n + 6; k++) begin
            if (bus.mac_clr) clr_n++;
            if (bus.mac_en)  en_n++;
            if (bus.result_valid && rv_k == 0) rv_k = k;
            bus.start = (k == restart_k);
            tick();
        end
        bus.start = 1'b0;
        check("mac_clr_cycles", 32'(clr_n), 32'd1);
        check("mac_en_cycles",  32'(en_n),  32'(n));
        check("rv_latency",     32'(rv_k),  32'(n + 3));
        check("idle_after_run", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load_valid = 1'b0;
        bus.load_data  = 8'd0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;

        // Reset state
        repeat (2) tick();
        check("rst_busy",   32'(bus.busy),   32'd0);
        check("rst_mac_en", 32'(bus.mac_en), 32'd0);
        check("rst_result", 32'(bus.result), 32'd0);
        check("rst_rv",     32'(bus.result_valid), 32'd0);
        rst = 1'b0;
        tick();
        check("load_ready_after_rst", 32'(bus.load_ready), 32'd1);

        // Basic: 3*4 + 5*6 = 42
        load(4'd3, 4'd4);
        load(4'd5, 4'd6);
        exp_q.push_back('{res: 8'd42, ovf: 1'b0, mis: 1'b0});
        run(2, 1'b0, 4'd0, 4'd0, 0);
        tick();
        check("result_hold", 32'(bus.result), 32'd42);

        // Start with empty buffer is ignored
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_empty_busy", 32'(bus.busy), 32'd0);
        check("start_empty_clr",  32'(bus.mac_clr), 32'd0);

        // Full buffer and overflow: 8*225 = 1800 -> 8 mod 256
        for (int i = 0; i < 8; i++) load(4'd15, 4'd15);
        check("full_load_ready", 32'(bus.load_ready), 32'd0);
        exp_q.push_back('{res: 8'd8, ovf: 1'b1, mis: 1'b0});
        run(8, 1'b0, 4'd0, 4'd0, 0);

        // Load in the start cycle with count=2, plus start while busy
        load(4'd1, 4'd2);
        load(4'd2, 4'd3);
        exp_q.push_back('{res: 8'd20, ovf: 1'b0, mis: 1'b0});
        run(3, 1'b1, 4'd3, 4'd4, 3);

        // Abort in the second ISSUE cycle of a 4-pair run
        for (int i = 0; i < 4; i++) load(4'd1, 4'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        check("abort_in_issue", 32'(bus.mac_en), 32'd1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy",       32'(bus.busy),       32'd0);
        check("abort_load_ready", 32'(bus.load_ready), 32'd1);
        repeat (6) tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("abort_count_zero", 32'(bus.busy), 32'd0);

        // Reset in the middle of ISSUE, then a fresh (2,2) run
        load(4'd7, 4'd7);
        load(4'd7, 4'd7);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        check("midrst_mac_en",  32'(bus.mac_en),  32'd0);
        check("midrst_mac_a",   32'(bus.mac_a),   32'd0);
        check("midrst_busy",    32'(bus.busy),    32'd0);
        check("midrst_result",  32'(bus.result),  32'd0);
        check("midrst_overflow",32'(bus.overflow),32'd0);
        tick();
        rst = 1'b0;
        tick();
        load(4'd2, 4'd2);
        exp_q.push_back('{res: 8'd4, ovf: 1'b0, mis: 1'b0});
        run(1, 1'b0, 4'd0, 4'd0, 0);

        // Faulty MAC adds 1 on the last pair: 1+1+1 = 3, shadow 2
        inject_at = 1;
        load(4'd1, 4'd1);
        load(4'd1, 4'd1);
        exp_q.push_back('{res: 8'd3, ovf: 1'b0, mis: 1'b1});
        run(2, 1'b0, 4'd0, 4'd0, 0);
        inject_at = -1;

        repeat (3) tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mac_dot_sequencer.md
MAC_DOT_SEQUENCER -- requirements
Module: mac_dot_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, operand-pair buffer depth (power of 2, 2..16).
REQ-002 SHALL have parameter SUMW, default 8+$clog2(DEPTH), width of the shadow sum.
REQ-003 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port load_valid  input  1  operand pair offered.
REQ-006 SHALL have port load_data  input  8  [3:0]=a, [7:4]=b, unsigned.
REQ-007 SHALL have port load_ready  output  1  buffer accepts a pair this cycle.
REQ-008 SHALL have port start  input  1  begin dot-product run.
REQ-009 SHALL have port abort  input  1  cancel the run in progress.
REQ-010 SHALL have port mac_a  output  4  operand a to the MAC.
REQ-011 SHALL have port mac_b  output  4  operand b to the MAC.
REQ-012 SHALL have port mac_en  output  1  MAC accumulates a*b on this edge.
REQ-013 SHALL have port mac_clr  output  1  MAC accumulator clears on this edge.
REQ-014 SHALL have port mac_acc  input  8  registered MAC accumulator value.
REQ-015 SHALL have port result  output  8  captured accumulator.
REQ-016 SHALL have port result_valid  output  1  one-cycle pulse, result is valid.
REQ-017 SHALL have port overflow  output  1  true sum exceeded 255 (qualified by result_valid).
REQ-018 SHALL have port mismatch  output  1  mac_acc differed from the shadow sum (qualified by result_valid).
REQ-019 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-020 SHALL implement FSM states IDLE, CLEAR, ISSUE, DRAIN, DONE.
REQ-021 SHALL drive load_ready = (state==IDLE) && (count<DEPTH); a pair is accepted when load_valid && load_ready, written at wr_ptr, then wr_ptr++ and count++.
REQ-022 SHALL, in IDLE with start=1 and count>0 (count includes a pair accepted in the same cycle), move to CLEAR.
REQ-023 SHALL ignore start when count==0 or when busy.
REQ-024 SHALL, in CLEAR, assert mac_clr=1 for exactly one cycle, clear the shadow sum, set rd_ptr=0, and move to ISSUE.
REQ-025 SHALL, in ISSUE, assert mac_en=1 each cycle with mac_a/mac_b = buffer[rd_ptr] and shadow += a*b (zero-extended to SUMW), then rd_ptr++; after the count-th pair it moves to DRAIN.
REQ-026 SHALL hold mac_a, mac_b, mac_en, and mac_clr at 0 outside CLEAR/ISSUE.
REQ-027 SHALL, in DRAIN (one cycle), register result<=mac_acc, overflow<=(shadow>255), and mismatch<=(mac_acc!=shadow[7:0]), then move to DONE.
REQ-028 SHALL, in DONE, assert result_valid=1 for one cycle, clear count/wr_ptr/rd_ptr, and return to IDLE; result/overflow/mismatch hold until the next DRAIN.
REQ-029 SHALL give latency: start sampled at edge t results in CLEAR in cycle t+1, ISSUE in t+2..t+1+N, DRAIN in t+2+N, and result_valid in cycle t+3+N.
REQ-030 SHALL, on abort=1 in any busy state, return to IDLE next edge, clear count/pointers, and produce no result_valid; abort in IDLE clears count/pointers.
REQ-031 SHALL give abort priority over start, and start/load priority only in IDLE.
REQ-032 SHALL not require buffer contents to be cleared, since count governs validity.

Reset
REQ-033 SHALL, on rst=1, immediately force state=IDLE, count=wr_ptr=rd_ptr=0, shadow=0, result=0, result_valid=overflow=mismatch=0, mac_en=mac_clr=0, mac_a=mac_b=0, busy=0; load_ready=1 after release.
REQ-034 SHALL, when rst is asserted mid-run, discard the run with no result_valid emitted.

Verification
REQ-035 SHALL cover basic: load (a=3,b=4),(5,6), start -> mac_clr one cycle, two mac_en cycles, result=42, overflow=0, mismatch=0, result_valid at t+5.
REQ-036 SHALL cover full/overflow: load 8 pairs (15,15) -> load_ready=0 after the 8th; start -> result=8 (1800 mod 256), overflow=1.
REQ-037 SHALL cover simultaneous events: a load and start in the same cycle with count=2 -> 3 pairs issued; start with count=0 -> no state change; start while busy -> ignored.
REQ-038 SHALL cover abort: abort in the 2nd ISSUE cycle of a 4-pair run -> IDLE next edge, no result_valid, count=0, load_ready=1.
REQ-039 SHALL cover reset in the middle of ISSUE: all outputs 0 immediately; a new run of (2,2) afterwards yields result=4.
REQ-040 SHALL cover checker: a MAC model returns acc+1 on the last pair for (1,1),(1,1) -> result=3, mismatch=1.
